iface_chan_pipe: RTL and testbench

Parametrised multi-channel successor to the single-interface top-level test block. It sits directly under the top module and flattens a per-channel configuration interface onto plain ports. It provides CHANNELS independent registered signal-transform lanes, each with its own configuration registers. It also carries a DEPTH-entry valid/ready buffered data pass-through with optional bit-reversal, and a wrap-around transfer counter.

---
 rtl/iface_chan_pkg.sv | 25 ++
 rtl/iface_chan_fifo.sv | 50 +++++
 rtl/iface_chan_pipe.sv | 79 +++++++
 tb/tb_iface_chan_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/iface_chan_pkg.sv
// Shared types, constants and helpers for the multi-channel interface pipe.
package iface_chan_pkg;

  localparam int unsigned CFG_CHAN_W = 3;
  localparam int unsigned REV_MAX_W  = 64;

  typedef struct packed {
    logic       setting;
    logic [2:0] other;
  } lane_cfg_t;

  // Reverses the low w bits of d; bits at and above w come back as zero.
  function automatic logic [REV_MAX_W-1:0] bit_reverse(input logic [REV_MAX_W-1:0] d,
                                                       input int unsigned w);
    logic [REV_MAX_W-1:0] r;
    logic [5:0]           idx;
    r = '0;
    for (int unsigned i = 0; i < REV_MAX_W; i++) begin
      idx = 6'(w - 1 - i);
      if (i < w) r[i] = d[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/iface_chan_fifo.sv
// DEPTH-entry synchronous FIFO with count-based ready/valid handshake.
module iface_chan_fifo #(
  parameter int unsigned W     = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Ready depends only on occupancy, so a full FIFO refuses data even while popping.
  assign inReady  = (count < FULL_CNT);
  assign outValid = (count != '0);
  assign push     = inValid & inReady;
  assign pop      = outValid & outReady;
  assign outData  = outValid ? mem[rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= inData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/iface_chan_pipe.sv
// Multi-channel lane transforms plus a buffered, optionally bit-reversed data pass-through.
module iface_chan_pipe
  import iface_chan_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SIG_W    = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*SIG_W-1:0] sig,
  input  logic                      flip,
  input  logic                      cfg_wr,
  input  logic [CFG_CHAN_W-1:0]     cfg_chan,
  input  logic                      cfg_setting,
  input  logic [2:0]                cfg_other,
  output logic [CHANNELS*SIG_W-1:0] sig_out,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [CNT_W-1:0]          xfer_cnt
);

  for (genvar c = 0; c < CHANNELS; c++) begin : gLane
    lane_cfg_t        cfg;
    logic [SIG_W-1:0] laneIn;
    logic [SIG_W-1:0] laneOut;
    logic [SIG_W+2:0] sum;

    assign laneIn = sig[c*SIG_W +: SIG_W];
    // Widened add covers SIG_W smaller or larger than the 3-bit offset; result truncates.
    assign sum = {3'b000, laneIn ^ {SIG_W{flip}}} + {{SIG_W{1'b0}}, cfg.other};
    assign sig_out[c*SIG_W +: SIG_W] = laneOut;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cfg     <= '0;
        laneOut <= '0;
      end else begin
        if (cfg_wr && cfg_chan == CFG_CHAN_W'(c))
          cfg <= '{setting: cfg_setting, other: cfg_other};
        laneOut <= cfg.setting ? sum[SIG_W-1:0] : laneIn;
      end
    end
  end

  logic [DATA_W:0]        fifoOut;
  logic [REV_MAX_W-1:0]   padded;
  logic [REV_MAX_W-1:0]   reversed;

  iface_chan_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .inData   ({in_data, flip}),
    .outValid (out_valid),
    .outReady (out_ready),
    .outData  (fifoOut)
  );

  assign padded   = REV_MAX_W'(fifoOut[DATA_W:1]);
  assign reversed = bit_reverse(padded, DATA_W);
  assign out_data = fifoOut[0] ? reversed[DATA_W-1:0] : fifoOut[DATA_W:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         xfer_cnt <= '0;
    else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_iface_chan_pipe.sv
// Directed and randomized checks of iface_chan_pipe against a queue-based reference model.
module tb_iface_chan_pipe;

  localparam int CH = 2;
  localparam int SW = 2;
  localparam int DW = 16;
  localparam int DP = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH*SW-1:0] sig;
  logic             flip;
  logic             cfg_wr;
  logic [2:0]       cfg_chan;
  logic             cfg_setting;
  logic [2:0]       cfg_other;
  logic [CH*SW-1:0] sig_out;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    xfer_cnt;

  iface_chan_pipe #(
    .CHANNELS (CH),
    .SIG_W    (SW),
    .DATA_W   (DW),
    .DEPTH    (DP),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig         (sig),
    .flip        (flip),
    .cfg_wr      (cfg_wr),
    .cfg_chan    (cfg_chan),
    .cfg_setting (cfg_setting),
    .cfg_other   (cfg_other),
    .sig_out     (sig_out),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .xfer_cnt    (xfer_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int            mSet [8];
  int            mOth [8];
  logic [DW:0]   q [$];
  int            mXfers;
  int            mSig;

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = d[DW-1-i];
    return r;
  endfunction

  // Arithmetic statement of the lane rule, applied to the current inputs and config.
  function automatic int laneModel();
    int res, s, mask;
    mask = (1 << SW) - 1;
    res  = 0;
    for (int c = 0; c < CH; c++) begin
      s = (int'(sig) >> (c*SW)) & mask;
      if (mSet[c] != 0) s = ((s ^ (flip ? mask : 0)) + mOth[c]) % (1 << SW);
      res = res | (s << (c*SW));
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [DW-1:0] front;
    check("sig_out",   32'(sig_out),   32'(mSig));
    check("in_ready",  32'(in_ready),  32'(q.size() < DP));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("xfer_cnt",  32'(xfer_cnt),  32'(mXfers % (1 << CW)));
    if (q.size() > 0) begin
      front = q[0][0] ? rev(q[0][DW:1]) : q[0][DW:1];
      check("out_data", 32'(out_data), 32'(front));
    end
  endtask

  task automatic step();
    bit push, pop;
    int nextSig;
    push    = in_valid && (q.size() < DP);
    pop     = out_ready && (q.size() > 0);
    nextSig = laneModel();
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      mXfers++;
    end
    if (push) q.push_back({in_data, flip});
    if (cfg_wr && cfg_chan < CH) begin
      mSet[cfg_chan] = int'(cfg_setting);
      mOth[cfg_chan] = int'(cfg_other);
    end
    mSig = nextSig;
    checkAll();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    q.delete();
    mXfers = 0;
    mSig   = 0;
    for (int i = 0; i < 8; i++) begin
      mSet[i] = 0;
      mOth[i] = 0;
    end
    checkAll();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll();
  endtask

  initial begin
    sig = '0; flip = 0; cfg_wr = 0; cfg_chan = '0; cfg_setting = 0; cfg_other = '0;
    in_valid = 0; in_data = '0; out_ready = 0;
    doReset();
    check("reset_out_data", 32'(out_data), 32'h0);

    // Idle pass-through of lane inputs
    sig = 4'b1001;
    step();
    check("idle_sig_out", 32'(sig_out), 32'h9);

    // Lane 1 enabled with offset 3, inverted input
    cfg_wr = 1; cfg_chan = 3'd1; cfg_setting = 1; cfg_other = 3'd3;
    step();
    cfg_wr = 0; flip = 1; sig = 4'b0101;
    step();
    check("lane1_xform", 32'(sig_out[3:2]), 32'h1);
    check("lane0_plain", 32'(sig_out[1:0]), 32'h1);

    // Out-of-range channel write must be ignored
    cfg_wr = 1; cfg_chan = 3'd5; cfg_setting = 1; cfg_other = 3'd7;
    step();
    cfg_wr = 0;
    step();
    check("ignored_wr", 32'(sig_out), 32'h5);

    // Fill the buffer, try a fifth push, then drain in order
    flip = 0; out_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = 16'(i);
      step();
    end
    check("full_ready", 32'(in_ready), 32'h0);
    in_data = 16'h0005;
    step();
    in_valid = 0; out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", 32'(out_data), 32'(i));
      step();
    end
    check("drain_cnt", 32'(xfer_cnt), 32'h4);

    // Bit-reversal latched at enqueue
    out_ready = 0; flip = 1; in_valid = 1; in_data = 16'h0001;
    step();
    in_valid = 0; flip = 0;
    check("rev_enq", 32'(out_data), 32'h8000);
    step();
    check("rev_hold", 32'(out_data), 32'h8000);
    out_ready = 1;
    step();

    // Randomized traffic and config writes
    for (int n = 0; n < 400; n++) begin
      sig         = CH*SW'($urandom);
      flip        = 1'($urandom);
      cfg_wr      = ($urandom_range(0, 7) == 0);
      cfg_chan    = 3'($urandom);
      cfg_setting = 1'($urandom);
      cfg_other   = 3'($urandom);
      in_valid    = 1'($urandom);
      in_data     = 16'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    cfg_wr = 0;

    // Counter wrap: 17 transfers on a 4-bit counter
    doReset();
    in_valid = 1; out_ready = 1;
    for (int n = 0; n < 100 && mXfers < 17; n++) begin
      in_data = 16'($urandom);
      step();
    end
    in_valid = 0;
    check("wrap_cnt", 32'(xfer_cnt), 32'h1);
    for (int n = 0; n < 10 && q.size() > 0; n++) step();
    check("drained", 32'(out_valid), 32'h0);

    // Asynchronous reset with two words buffered
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_data = 16'($urandom);
      step();
    end
    in_valid = 0;
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2;
    doReset();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_cnt",   32'(xfer_cnt),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
